// File: rtl/xg_palette_sched_pkg.sv
// Shared types for the XenonGecko palette write scheduler.
package xg_pal_pkg;

  localparam int PAL_ENTRIES = 256;

  // Palette colour, packed {b, g, r}.
  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } color_t;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    XPS_IDLE  = 2'd0,
    XPS_FILL  = 2'd1,
    XPS_DRAIN = 2'd2
  } xps_state_t;

  // One queued CPU palette update.
  typedef struct packed {
    logic [7:0] index;
    color_t     color;
  } pal_wr_t;

endpackage

// File: rtl/xg_palette_sched_if.sv
// CPU-side palette write request channel.
interface xg_pal_wr_if;
  import xg_pal_pkg::*;

  // Handshake: the master holds wr_index/wr_color stable while wr_req is high;
  // a write is transferred on every rising clk_25 edge where wr_req & wr_ready.
  // wr_ready depends only on registered FIFO occupancy, never on wr_req.
  // A request seen while wr_ready is low is dropped, not retried.
  logic   wr_req;
  logic   [7:0] wr_index;
  color_t wr_color;
  logic   wr_ready;

  modport master (output wr_req, output wr_index, output wr_color, input wr_ready);
  modport slave  (input wr_req, input wr_index, input wr_color, output wr_ready);

endinterface

// File: rtl/xg_palette_sched_fifo.sv
// Synchronous FIFO of pending palette writes with flush.
module xg_pal_fifo
  import xg_pal_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_25,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  pal_wr_t                  din,
  output pal_wr_t                  head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  pal_wr_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  // A full FIFO refuses pushes even if it pops in the same cycle.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush discards everything, including a same-cycle push.
  always_ff @(posedge clk_25) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk_25) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/xg_palette_sched.sv
// Palette RAM write scheduler: queues CPU writes and commits them, or a
// full-palette fill, only while the video pipeline is not reading the palette.
module xg_palette_sched
  import xg_pal_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk_25,
  input  logic                    rst,
  xg_pal_wr_if.slave              wr,
  input  logic                    fill_start,
  input  color_t                  fill_color,
  output logic                    fill_busy,
  input  logic                    vid_busy,
  input  logic                    active_render_rows,
  input  logic                    vblank_only,
  input  logic [7:0]              rd_index,
  output logic [7:0]              pal_address,
  output color_t                  pal_data,
  output logic                    pal_wren,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  input  logic                    ovf_clr,
  output xps_state_t              state_dbg
);

  localparam int LW = $clog2(DEPTH) + 1;

  xps_state_t state_q;
  xps_state_t state_d;
  logic [7:0] fill_ptr_q;
  logic [7:0] fill_ptr_d;
  color_t     fill_color_q;
  logic       win;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  pal_wr_t    fifo_din;
  pal_wr_t    fifo_head;

  // Writes may only land when the renderer is not reading the palette.
  assign win = ~vid_busy & (~vblank_only | ~active_render_rows);

  assign wr.wr_ready = ~fifo_full;
  assign push        = wr.wr_req & ~fifo_full;
  assign fifo_din    = '{index: wr.wr_index, color: wr.wr_color};

  xg_pal_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_25 (clk_25),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (fill_start),
    .din    (fifo_din),
    .head   (fifo_head),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // State and fill pointer registers.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q    <= XPS_IDLE;
      fill_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_ptr_q <= fill_ptr_d;
    end
  end

  // Next state, fill pointer advance, and write strobe; fill_start overrides everything.
  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    pal_wren   = 1'b0;
    pop        = 1'b0;
    case (state_q)
      XPS_IDLE: begin
        // Looking at push as well lets a write reach DRAIN one cycle after it is queued.
        if (!fifo_empty || push) state_d = XPS_DRAIN;
      end
      XPS_DRAIN: begin
        if (win && !fifo_empty) begin
          pal_wren = 1'b1;
          pop      = 1'b1;
          if (fifo_level == LW'(1) && !push) state_d = XPS_IDLE;
        end else if (fifo_empty && !push) begin
          state_d = XPS_IDLE;
        end
      end
      XPS_FILL: begin
        if (win) begin
          pal_wren   = 1'b1;
          fill_ptr_d = fill_ptr_q + 8'd1;
          if (fill_ptr_q == 8'(PAL_ENTRIES - 1)) begin
            state_d = (!fifo_empty || push) ? XPS_DRAIN : XPS_IDLE;
          end
        end
      end
      default: state_d = XPS_IDLE;
    endcase
    if (fill_start) begin
      state_d    = XPS_FILL;
      fill_ptr_d = '0;
    end
  end

  // Fill colour is captured on the start pulse so the source may change afterwards.
  always_ff @(posedge clk_25) begin
    if (rst)             fill_color_q <= '0;
    else if (fill_start) fill_color_q <= fill_color;
  end

  // Sticky overflow; a new drop beats a clear in the same cycle.
  always_ff @(posedge clk_25) begin
    if (rst)                          overflow <= 1'b0;
    else if (wr.wr_req && fifo_full)  overflow <= 1'b1;
    else if (ovf_clr)                 overflow <= 1'b0;
  end

  // Address/data mux: renderer index passes through whenever no write is strobed.
  always_comb begin
    pal_address = rd_index;
    pal_data    = (state_q == XPS_FILL) ? fill_color_q : fifo_head.color;
    if (pal_wren) pal_address = (state_q == XPS_FILL) ? fill_ptr_q : fifo_head.index;
  end

  assign fill_busy = (state_q == XPS_FILL);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_xg_palette_sched.sv
// Testbench for xg_palette_sched: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_xg_palette_sched;
  import xg_pal_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk_25 = 1'b0;
  logic rst    = 1'b1;
  always #20 clk_25 = ~clk_25;

  // ---------------- DUT ----------------
  xg_pal_wr_if wif ();
  logic          fill_start = 1'b0;
  logic [23:0]   fill_color = '0;
  logic          fill_busy;
  logic          vid_busy = 1'b1;
  logic          active_render_rows = 1'b1;
  logic          vblank_only = 1'b0;
  logic [7:0]    rd_index = '0;
  logic [7:0]    pal_address;
  logic [23:0]   pal_data;
  logic          pal_wren;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          ovf_clr = 1'b0;
  xps_state_t    state_dbg;

  xg_palette_sched #(.DEPTH(DEPTH)) dut (
    .clk_25             (clk_25),
    .rst                (rst),
    .wr                 (wif),
    .fill_start         (fill_start),
    .fill_color         (fill_color),
    .fill_busy          (fill_busy),
    .vid_busy           (vid_busy),
    .active_render_rows (active_render_rows),
    .vblank_only        (vblank_only),
    .rd_index           (rd_index),
    .pal_address        (pal_address),
    .pal_data           (pal_data),
    .pal_wren           (pal_wren),
    .fifo_level         (fifo_level),
    .overflow           (overflow),
    .ovf_clr            (ovf_clr),
    .state_dbg          (state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];      // pending CPU writes, {index, colour}, oldest first
  int          fill_rem;      // fill entries still to be written
  logic [7:0]  fill_next;     // next fill entry
  logic [23:0] fill_col_m;
  logic        ovf_m;
  logic [23:0] ram [256];     // palette contents as seen on the write port

  // video timing model (640x480: 800 cols, 525 rows)
  bit timing_en = 1'b0;
  int col = 0;
  int row = 0;
  int last_wr_row, last_wr_col, first_wr_row, first_wr_col;
  logic [7:0] addr_at_798;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock cycle: settle, compare against the model, advance the model.
  task automatic step();
    logic        w;
    logic        exp_wren;
    logic [7:0]  exp_addr;
    logic [23:0] exp_data;
    bit          full_before;
    if (timing_en) begin
      active_render_rows = (row < 480);
      vid_busy = (row < 480) && ((col < 652) || (col == 799));
    end
    #1;
    w        = ~vid_busy & (~vblank_only | ~active_render_rows);
    exp_wren = w && ((fill_rem > 0) || (exp_q.size() > 0));
    exp_addr = rd_index;
    exp_data = '0;
    if (fill_rem > 0) begin
      exp_addr = fill_next;
      exp_data = fill_col_m;
    end else if (exp_q.size() > 0) begin
      exp_addr = exp_q[0][31:24];
      exp_data = exp_q[0][23:0];
    end
    if (!rst) begin
      chk("wren", pal_wren, exp_wren);
      if (exp_wren) begin
        chk("wr_addr", pal_address, exp_addr);
        chk("wr_data", pal_data, exp_data);
      end else begin
        chk("rd_addr", pal_address, rd_index);
      end
      chk("level", fifo_level, exp_q.size());
      chk("wr_ready", wif.wr_ready, exp_q.size() < DEPTH);
      chk("fill_busy", fill_busy, fill_rem > 0);
      chk("overflow", overflow, ovf_m);
      if (pal_wren) begin
        ram[pal_address] = pal_data;
        last_wr_row = row;
        last_wr_col = col;
        if (first_wr_row < 0) begin
          first_wr_row = row;
          first_wr_col = col;
        end
        if (timing_en && col == 798 && row == 10) addr_at_798 = pal_address;
      end
    end
    if (rst) begin
      exp_q.delete();
      fill_rem  = 0;
      fill_next = '0;
      ovf_m     = 1'b0;
    end else begin
      full_before = (exp_q.size() >= DEPTH);
      if (exp_wren) begin
        if (fill_rem > 0) begin
          fill_rem--;
          fill_next++;
        end else begin
          void'(exp_q.pop_front());
        end
      end
      if (fill_start) begin
        exp_q.delete();
        fill_rem   = 256;
        fill_next  = '0;
        fill_col_m = fill_color;
      end else if (wif.wr_req && !full_before) begin
        exp_q.push_back({wif.wr_index, wif.wr_color});
      end
      if (wif.wr_req && full_before) ovf_m = 1'b1;
      else if (ovf_clr)              ovf_m = 1'b0;
    end
    @(posedge clk_25);
    if (timing_en) begin
      col++;
      if (col == 800) begin
        col = 0;
        row = (row + 1) % 525;
      end
    end
    @(negedge clk_25);
  endtask

  task automatic push_one(input logic [7:0] idx, input logic [23:0] c);
    wif.wr_req   = 1'b1;
    wif.wr_index = idx;
    wif.wr_color = c;
    step();
    wif.wr_req   = 1'b0;
  endtask

  // Global bound so a stuck run still terminates.
  initial begin
    #4_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int bad;
    int busy_pct;
    wif.wr_req   = 1'b0;
    wif.wr_index = '0;
    wif.wr_color = '0;
    fill_rem     = 0;
    fill_next    = '0;
    fill_col_m   = '0;
    ovf_m        = 1'b0;
    first_wr_row = -1;
    first_wr_col = -1;
    last_wr_row  = -1;
    last_wr_col  = -1;
    addr_at_798  = '0;
    for (int i = 0; i < 256; i++) ram[i] = '0;

    @(negedge clk_25);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset values
    rd_index = 8'h3C;
    vid_busy = 1'b0;
    #1;
    chk("rst_wr_ready", wif.wr_ready, 1);
    chk("rst_fill_busy", fill_busy, 0);
    chk("rst_wren", pal_wren, 0);
    chk("rst_addr", pal_address, 8'h3C);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);

    // Idle pass-through for 100 cycles
    repeat (100) step();
    #1 chk("idle_addr", pal_address, 8'h3C);

    // Single write held off by vid_busy
    vid_busy = 1'b1;
    push_one(8'h05, 24'h00FF00);
    repeat (19) step();
    #1 chk("busy_hold_level", fifo_level, 1);
    vid_busy = 1'b0;
    #1;
    chk("win_wren", pal_wren, 1);
    chk("win_addr", pal_address, 8'h05);
    chk("win_data", pal_data, 24'h00FF00);
    step();
    #1 chk("win_level0", fifo_level, 0);

    // Overflow: 17 pushes into a 16-entry FIFO with no window
    vid_busy = 1'b1;
    for (int i = 0; i < 17; i++) push_one(8'(8'h60 + i), 24'($urandom));
    #1;
    chk("ovf_ready", wif.wr_ready, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", fifo_level, 16);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    #1;
    chk("ovf_clr", overflow, 0);
    chk("ovf_clr_level", fifo_level, 16);
    vid_busy = 1'b0;
    repeat (20) step();
    #1 chk("ovf_drained", fifo_level, 0);

    // Fill under 640x480 timing, started at col 0 of row 10
    timing_en    = 1'b1;
    row          = 10;
    col          = 0;
    fill_color   = 24'h123456;
    fill_start   = 1'b1;
    step();
    fill_start   = 1'b0;
    for (int i = 0; i < 3000 && fill_rem > 0; i++) step();
    #1 chk("fill_done_busy", fill_busy, 0);
    chk("fill_blank1_last", addr_at_798, 146);
    chk("fill_last_row", last_wr_row, 11);
    chk("fill_last_col", last_wr_col, 760);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== 24'h123456) bad++;
    chk("fill_ram_bad", bad, 0);
    timing_en = 1'b0;

    // Queued writes flushed by fill; later writes survive
    vid_busy = 1'b1;
    push_one(8'h20, 24'hAA0001);
    push_one(8'h21, 24'hAA0002);
    push_one(8'h22, 24'hAA0003);
    fill_color   = 24'h0A0B0C;
    fill_start   = 1'b1;
    push_one(8'h30, 24'h777777);
    fill_start   = 1'b0;
    push_one(8'h10, 24'hABCDEF);
    #1 chk("flush_level", fifo_level, 1);
    vid_busy = 1'b0;
    repeat (300) step();
    chk("flush_e10", ram[8'h10], 24'hABCDEF);
    chk("flush_e20", ram[8'h20], 24'h0A0B0C);
    chk("flush_e22", ram[8'h22], 24'h0A0B0C);
    chk("flush_e30", ram[8'h30], 24'h0A0B0C);
    chk("flush_e11", ram[8'h11], 24'h0A0B0C);

    // vblank_only: push in a visible row's h-blank waits for v-blank
    vblank_only  = 1'b1;
    timing_en    = 1'b1;
    row          = 478;
    col          = 660;
    first_wr_row = -1;
    push_one(8'h44, 24'h445566);
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) step();
    chk("vbl_row", first_wr_row, 480);
    chk("vbl_col", first_wr_col, 0);
    chk("vbl_data", ram[8'h44], 24'h445566);
    timing_en   = 1'b0;
    vblank_only = 1'b0;

    // Randomized traffic with a mid-run reset
    for (int blk = 0; blk < 16; blk++) begin
      busy_pct    = $urandom_range(0, 100);
      vblank_only = 1'($urandom_range(0, 1));
      for (int i = 0; i < 200; i++) begin
        vid_busy           = ($urandom_range(0, 99) < busy_pct);
        active_render_rows = 1'($urandom_range(0, 1));
        wif.wr_req         = 1'($urandom_range(0, 1));
        wif.wr_index       = 8'($urandom);
        wif.wr_color       = 24'($urandom);
        fill_start         = ($urandom_range(0, 299) == 0);
        fill_color         = 24'($urandom);
        ovf_clr            = ($urandom_range(0, 15) == 0);
        rd_index           = 8'($urandom);
        rst                = (blk == 8 && i == 100);
        step();
      end
    end
    wif.wr_req = 1'b0;
    fill_start = 1'b0;
    ovf_clr    = 1'b0;
    rst        = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
